// File: rtl/conv_cfu_pkg.sv
// Shared definitions for the 3x3x4 MAC convolution CFU: function-id groups/ops,
// controller state encodings and the window-priming function-id helper.
package conv_cfu_pkg;

   localparam int OUT_DIM = 28;

   localparam logic [6:0] GRP_COMPUTE = 7'd0;
   localparam logic [6:0] GRP_ACC     = 7'd3;
   localparam logic [6:0] GRP_IN_A    = 7'd4;
   localparam logic [6:0] GRP_IN_B    = 7'd5;

   localparam logic [2:0] OP_COMPUTE  = 3'd1;
   localparam logic [2:0] OP_ACC      = 3'd1;
   localparam logic [2:0] OP_SHIFT_1  = 3'd4;
   localparam logic [2:0] OP_SHIFT_2  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_CMP,
      ST_ACC,
      ST_SH1,
      ST_SH2,
      ST_DONE
   } seq_state_t;

   // Every step of a row runs through these phases; steps without a fetch enter at PH_ISSUE.
   typedef enum logic [1:0] {
      PH_FETCH,
      PH_CAPT,
      PH_ISSUE,
      PH_WAIT
   } seq_phase_t;

   typedef enum logic [1:0] {
      M_IDLE,
      M_CMD,
      M_RSP
   } cmd_state_t;

   // Window rows 0/1 load through group IN_A (ops 1..6), row 2 through IN_B (ops 1..3).
   function automatic logic [9:0] prime_fid(input logic [1:0] row, input logic [1:0] col);
      logic [6:0] grp;
      logic [2:0] op;
      grp = (row == 2'd2) ? GRP_IN_B : GRP_IN_A;
      op  = (row == 2'd1) ? 3'(col) + 3'd4 : 3'(col) + 3'd1;
      return {grp, op};
   endfunction

endpackage

// File: rtl/dp_cmd_master.sv
// One-shot CFU command/response handshake engine: latches a command on issue,
// holds it until accepted, then waits for (and discards) the response.
module dp_cmd_master
   import conv_cfu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        issue,
   input  logic [9:0]  issue_fid,
   input  logic [31:0] issue_in_0,
   input  logic [31:0] issue_in_1,
   output logic        idle,
   output logic        rsp_done,
   output logic        dp_cmd_valid,
   input  logic        dp_cmd_ready,
   output logic [9:0]  dp_function_id,
   output logic [31:0] dp_inputs_0,
   output logic [31:0] dp_inputs_1,
   input  logic        dp_rsp_valid,
   output logic        dp_rsp_ready
);

   cmd_state_t state_q, state_d;

   always_comb begin
      // NOTE: default every always_comb output first so no path leaves it unassigned (latch).
      state_d = state_q;
      case (state_q)
         M_IDLE:  if (issue)        state_d = M_CMD;
         M_CMD:   if (dp_cmd_ready) state_d = M_RSP;
         M_RSP:   if (dp_rsp_valid) state_d = M_IDLE;
         default:                   state_d = M_IDLE;
      endcase
   end

   assign idle         = (state_q == M_IDLE);
   assign dp_cmd_valid = (state_q == M_CMD);
   assign dp_rsp_ready = (state_q == M_RSP);
   assign rsp_done     = dp_rsp_ready && dp_rsp_valid;

   // NOTE: every register, payload included, is cleared by reset_n because the payload drives ports directly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= M_IDLE;
         dp_function_id <= '0;
         dp_inputs_0    <= '0;
         dp_inputs_1    <= '0;
      end else begin
         // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
         state_q <= state_d;
         if (issue && idle) begin
            dp_function_id <= issue_fid;
            dp_inputs_0    <= issue_in_0;
            dp_inputs_1    <= issue_in_1;
         end
      end
   end

endmodule

// File: rtl/conv_row_sequencer.sv
// Row sequencer for the 3x3x4 MAC CFU: primes the 9-word window, then loops over output
// columns issuing compute/accumulate/shift commands. `define CONV_SEQ_PERF_EN adds perf_cycles.
module conv_row_sequencer #(
   parameter int ADDR_W  = 16,
   parameter int COL_W   = 5,
   parameter int OUT_DIM = conv_cfu_pkg::OUT_DIM
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_stride,
   input  logic [COL_W-1:0]  cfg_out_row,
   input  logic [COL_W:0]    cfg_n_cols,
   output logic              busy,
   output logic              done,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic              dp_cmd_valid,
   input  logic              dp_cmd_ready,
   output logic [9:0]        dp_function_id,
   output logic [31:0]       dp_inputs_0,
   output logic [31:0]       dp_inputs_1,
   input  logic              dp_rsp_valid,
   output logic              dp_rsp_ready
`ifdef CONV_SEQ_PERF_EN
   ,
   output logic [31:0]       perf_cycles
`endif
);

   import conv_cfu_pkg::*;

   localparam logic [COL_W:0] N_MAX = (COL_W+1)'(OUT_DIM);
   localparam logic [COL_W:0] ONE   = (COL_W+1)'(1);
   localparam logic [COL_W:0] THREE = (COL_W+1)'(3);

   seq_state_t        state_q, state_d;
   seq_phase_t        phase_q, phase_d;
   logic [ADDR_W-1:0] base_q, stride_q, row_off;
   logic [COL_W-1:0]  out_row_q;
   logic [COL_W:0]    n_q, k_q, n_in, f_col;
   logic [1:0]        r_q, c_q, f_row;
   logic [31:0]       data_q, pay_0, pay_1;
   logic [9:0]        fid;
   logic              accept, active, last_col, issue, m_idle, m_rsp_done;

   assign n_in     = (cfg_n_cols > N_MAX) ? N_MAX : cfg_n_cols;
   assign accept   = (state_q == ST_IDLE) && start;
   assign active   = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign busy     = active;
   assign last_col = (k_q == n_q - ONE);

   // Fetch address: window (r, c) in priming, column k+3 of row 0/1/2 while shifting.
   always_comb begin
      f_row = 2'd0;
      f_col = k_q + THREE;
      case (state_q)
         ST_PRIME: begin
            f_row = r_q;
            f_col = (COL_W+1)'(c_q);
         end
         ST_SH1:  f_row = 2'd1;
         ST_SH2:  f_row = 2'd2;
         default: ;
      endcase
      row_off  = (f_row == 2'd0) ? '0 : (f_row == 2'd1) ? stride_q : stride_q + stride_q;
      mem_ren  = active && (phase_q == PH_FETCH);
      mem_addr = mem_ren ? base_q + row_off + ADDR_W'(f_col) : '0;
   end

   always_comb begin
      fid   = {GRP_COMPUTE, OP_COMPUTE};
      pay_0 = data_q;
      pay_1 = '0;
      case (state_q)
         ST_PRIME: fid = prime_fid(r_q, c_q);
         ST_CMP:   if (last_col) pay_0 = '0;
         ST_ACC: begin
            fid   = {GRP_ACC, OP_ACC};
            pay_0 = 32'(out_row_q);
            pay_1 = 32'(k_q);
         end
         ST_SH1:   fid = {GRP_IN_B, OP_SHIFT_1};
         ST_SH2:   fid = {GRP_IN_B, OP_SHIFT_2};
         default:  ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      issue   = 1'b0;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: if (start) begin
            state_d = (n_in == '0) ? ST_DONE : ST_PRIME;
            phase_d = PH_FETCH;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: case (phase_q)
            PH_FETCH: phase_d = PH_CAPT;
            PH_CAPT:  phase_d = PH_ISSUE;
            PH_ISSUE: if (m_idle) begin
               issue   = 1'b1;
               phase_d = PH_WAIT;
            end
            PH_WAIT: if (m_rsp_done) begin
               phase_d = PH_FETCH;
               case (state_q)
                  ST_PRIME: if (r_q == 2'd2 && c_q == 2'd2) begin
                     state_d = ST_CMP;
                     if (last_col) phase_d = PH_ISSUE;
                  end
                  ST_CMP: begin
                     state_d = ST_ACC;
                     phase_d = PH_ISSUE;
                  end
                  ST_ACC:  state_d = last_col ? ST_DONE : ST_SH1;
                  ST_SH1:  state_d = ST_SH2;
                  ST_SH2: begin
                     // The final column computes without fetching a new input word.
                     state_d = ST_CMP;
                     if (k_q + ONE == n_q - ONE) phase_d = PH_ISSUE;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         phase_q   <= PH_FETCH;
         base_q    <= '0;
         stride_q  <= '0;
         out_row_q <= '0;
         n_q       <= '0;
         k_q       <= '0;
         r_q       <= '0;
         c_q       <= '0;
         data_q    <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         if (accept) begin
            base_q    <= cfg_base;
            stride_q  <= cfg_stride;
            out_row_q <= cfg_out_row;
            n_q       <= n_in;
            k_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
         end
         if (active && phase_q == PH_CAPT) data_q <= mem_rdata;
         if (state_q == ST_PRIME && m_rsp_done) begin
            if (c_q == 2'd2) begin
               c_q <= '0;
               r_q <= r_q + 2'd1;
            end else begin
               c_q <= c_q + 2'd1;
            end
         end
         if (state_q == ST_SH2 && m_rsp_done) k_q <= k_q + ONE;
      end
   end

`ifdef CONV_SEQ_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        perf_cycles <= '0;
      else if (accept)                     perf_cycles <= '0;
      else if (busy && perf_cycles != '1)  perf_cycles <= perf_cycles + 32'd1;
   end
`endif

   dp_cmd_master u_cmd (
      .clk            (clk),
      .reset_n        (reset_n),
      .issue          (issue),
      .issue_fid      (fid),
      .issue_in_0     (pay_0),
      .issue_in_1     (pay_1),
      .idle           (m_idle),
      .rsp_done       (m_rsp_done),
      .dp_cmd_valid   (dp_cmd_valid),
      .dp_cmd_ready   (dp_cmd_ready),
      .dp_function_id (dp_function_id),
      .dp_inputs_0    (dp_inputs_0),
      .dp_inputs_1    (dp_inputs_1),
      .dp_rsp_valid   (dp_rsp_valid),
      .dp_rsp_ready   (dp_rsp_ready)
   );

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Bench for conv_row_sequencer: memory + datapath responders, a list-based model of the
// expected command/read sequence per row, table vectors, corner cases and random rows.
`timescale 1ns/1ps
module tb_conv_row_sequencer;

   typedef struct packed {
      logic [9:0]  fid;
      logic [31:0] in0;
      logic [31:0] in1;
   } cmd_t;

   typedef struct {
      logic [15:0] base;
      logic [15:0] stride;
      logic [4:0]  out_row;
      logic [5:0]  n_cols;
      int          rdy;
      int          rsp;
      logic [31:0] xr;
      int          exp_cmds;
      int          exp_reads;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] cfg_base = '0, cfg_stride = '0;
   logic [4:0]  cfg_out_row = '0;
   logic [5:0]  cfg_n_cols = '0;
   logic        busy, done, mem_ren, dp_cmd_valid, dp_rsp_ready;
   logic [15:0] mem_addr;
   logic [31:0] mem_rdata = '0;
   logic        dp_cmd_ready = 1'b0, dp_rsp_valid = 1'b0;
   logic [9:0]  dp_function_id;
   logic [31:0] dp_inputs_0, dp_inputs_1;
`ifdef CONV_SEQ_PERF_EN
   logic [31:0] perf_cycles;
`endif

   conv_row_sequencer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .cfg_base       (cfg_base),
      .cfg_stride     (cfg_stride),
      .cfg_out_row    (cfg_out_row),
      .cfg_n_cols     (cfg_n_cols),
      .busy           (busy),
      .done           (done),
      .mem_ren        (mem_ren),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .dp_cmd_valid   (dp_cmd_valid),
      .dp_cmd_ready   (dp_cmd_ready),
      .dp_function_id (dp_function_id),
      .dp_inputs_0    (dp_inputs_0),
      .dp_inputs_1    (dp_inputs_1),
      .dp_rsp_valid   (dp_rsp_valid),
      .dp_rsp_ready   (dp_rsp_ready)
`ifdef CONV_SEQ_PERF_EN
      ,
      .perf_cycles    (perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory content and datapath latency knobs shared by responder and model.
   logic [31:0] mem_xor = '0;
   bit          rand_dly = 1'b0;
   int          ready_dly = 0, rsp_dly = 0;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {16'h0, a} ^ mem_xor;
   endfunction

   function automatic cmd_t mk_cmd(input int grp, input int op, input logic [31:0] a, input logic [31:0] b);
      cmd_t c;
      c.fid = 10'(grp * 8 + op);
      c.in0 = a;
      c.in1 = b;
      return c;
   endfunction

   cmd_t        got_q[$], exp_q[$];
   logic [15:0] rd_q[$], exp_rd[$];
   int          done_cnt, busy_cnt, ren_cnt, valid_cnt, stab_err, proto_err;

   // Responder/monitor: runs on the falling edge, drives inputs for the next rising edge.
   initial begin
      bit          ren_prev = 1'b0, rsp_pending = 1'b0, cmd_open = 1'b0;
      logic [15:0] addr_prev = '0;
      int          ready_cnt = 0, rsp_cnt = 0;
      cmd_t        cur = '0, now_cmd;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            ren_prev = 1'b0; rsp_pending = 1'b0; cmd_open = 1'b0;
            dp_cmd_ready = 1'b0; dp_rsp_valid = 1'b0; mem_rdata = '0;
            continue;
         end
         mem_rdata = ren_prev ? mem_word(addr_prev) : 32'hDEAD_BEEF;
         ren_prev  = mem_ren;
         addr_prev = mem_addr;
         if (mem_ren) begin rd_q.push_back(mem_addr); ren_cnt++; end
         if (done) done_cnt++;
         if (busy) busy_cnt++;
         if (dp_cmd_valid) valid_cnt++;
         dp_rsp_valid = 1'b0;
         now_cmd = {dp_function_id, dp_inputs_0, dp_inputs_1};
         if (rsp_pending) begin
            dp_cmd_ready = 1'b0;
            if (dp_cmd_valid || !dp_rsp_ready) proto_err++;
            if (rsp_cnt == 0) begin
               dp_rsp_valid = 1'b1;
               rsp_pending  = 1'b0;
            end else rsp_cnt--;
         end else begin
            if (dp_rsp_ready) proto_err++;
            if (dp_cmd_valid) begin
               if (!cmd_open) begin
                  cmd_open  = 1'b1;
                  cur       = now_cmd;
                  got_q.push_back(now_cmd);
                  ready_cnt = rand_dly ? int'($urandom_range(0, 5)) : ready_dly;
               end else if (now_cmd != cur) stab_err++;
               if (ready_cnt == 0) begin
                  dp_cmd_ready = 1'b1;
                  cmd_open     = 1'b0;
                  rsp_pending  = 1'b1;
                  rsp_cnt      = rand_dly ? int'($urandom_range(0, 3)) : rsp_dly;
               end else begin
                  dp_cmd_ready = 1'b0;
                  ready_cnt--;
               end
            end else begin
               dp_cmd_ready = 1'b0;
               if (cmd_open) proto_err++;
            end
         end
      end
   end

   // Expected traffic for one row, straight from the window/column rules.
   task automatic build_model(input logic [15:0] base, input logic [15:0] stride,
                              input logic [4:0] out_row, input int n_req);
      int          n;
      logic [15:0] a;
      n = (n_req > 28) ? 28 : n_req;
      exp_q.delete();
      exp_rd.delete();
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (n == 0) continue;
            a = 16'(int'(base) + r * int'(stride) + c);
            exp_rd.push_back(a);
            exp_q.push_back(mk_cmd(r < 2 ? 4 : 5, r < 2 ? 3 * r + c + 1 : c + 1, mem_word(a), 0));
         end
      end
      for (int k = 0; k < n; k++) begin
         if (k < n - 1) begin
            a = 16'(int'(base) + k + 3);
            exp_rd.push_back(a);
            exp_q.push_back(mk_cmd(0, 1, mem_word(a), 0));
            exp_q.push_back(mk_cmd(3, 1, 32'(out_row), 32'(k)));
            for (int r = 1; r < 3; r++) begin
               a = 16'(int'(base) + r * int'(stride) + k + 3);
               exp_rd.push_back(a);
               exp_q.push_back(mk_cmd(5, 3 + r, mem_word(a), 0));
            end
         end else begin
            exp_q.push_back(mk_cmd(0, 1, 0, 0));
            exp_q.push_back(mk_cmd(3, 1, 32'(out_row), 32'(k)));
         end
      end
   endtask

   task automatic clear_obs();
      got_q.delete(); rd_q.delete();
      done_cnt = 0; busy_cnt = 0; ren_cnt = 0; valid_cnt = 0; stab_err = 0; proto_err = 0;
   endtask

   task automatic pulse_start(input logic [15:0] base, input logic [15:0] stride,
                              input logic [4:0] out_row, input logic [5:0] n_cols);
      @(negedge clk);
      cfg_base = base; cfg_stride = stride; cfg_out_row = out_row; cfg_n_cols = n_cols;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // Latched configuration must survive changes on the inputs.
      cfg_base = 16'($urandom); cfg_stride = 16'($urandom);
      cfg_out_row = 5'($urandom); cfg_n_cols = 6'($urandom);
   endtask

   task automatic run_row(input string tag, input logic [15:0] base, input logic [15:0] stride,
                          input logic [4:0] out_row, input logic [5:0] n_cols, input bit disturb);
      int cyc;
      bit seen;
      build_model(base, stride, out_row, int'(n_cols));
      clear_obs();
      pulse_start(base, stride, out_row, n_cols);
      if (n_cols == 0) check({tag, " done_next_cycle"}, done, 1'b1);
      else             check({tag, " busy_after_start"}, busy, 1'b1);
      seen = done;
      cyc  = 0;
      while (!seen && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         if (disturb && cyc == 15) begin
            start = 1'b1;
            cfg_n_cols = 6'd1;
         end
         if (disturb && cyc == 16) start = 1'b0;
         seen = done;
      end
      check({tag, " done_in_budget"}, seen, 1'b1);
      repeat (4) @(negedge clk);
      check({tag, " done_pulses"}, done_cnt, 1);
      check({tag, " idle_after"}, busy, 1'b0);
      check({tag, " cmd_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s cmd[%0d]", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
      check({tag, " read_count"}, rd_q.size(), exp_rd.size());
      for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
         check($sformatf("%s rd[%0d]", tag, i), rd_q[i], exp_rd[i]);
      check({tag, " payload_stable"}, stab_err, 0);
      check({tag, " handshake_order"}, proto_err, 0);
      if (n_cols == 0) check({tag, " no_traffic"}, {ren_cnt, valid_cnt, busy_cnt}, 96'd0);
`ifdef CONV_SEQ_PERF_EN
      check({tag, " perf_cycles"}, perf_cycles, busy_cnt);
`endif
   endtask

   vec_t vecs[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      vecs[0] = '{16'd0,      16'd30,     5'd2,  6'd1,  0, 0, 32'h0,         11,  9};
      vecs[1] = '{16'd0,      16'd30,     5'd2,  6'd3,  0, 0, 32'h0,         19,  15};
      vecs[2] = '{16'd0,      16'd30,     5'd2,  6'd3,  5, 3, 32'h0,         19,  15};
      vecs[3] = '{16'd100,    16'd7,      5'd5,  6'd0,  0, 0, 32'h0,         0,   0};
      vecs[4] = '{16'hFFF0,   16'h8000,   5'd27, 6'd40, 1, 2, 32'hA5A5_0000, 119, 90};
      vecs[5] = '{16'd200,    16'd28,     5'd0,  6'd28, 0, 1, 32'h1234_5678, 119, 90};

      repeat (3) @(negedge clk);
      check("reset_outputs",
            {busy, done, mem_ren, mem_addr, dp_cmd_valid, dp_rsp_ready, dp_function_id, dp_inputs_0, dp_inputs_1},
            '0);
      reset_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         ready_dly = vecs[i].rdy;
         rsp_dly   = vecs[i].rsp;
         mem_xor   = vecs[i].xr;
         run_row($sformatf("vec%0d", i), vecs[i].base, vecs[i].stride, vecs[i].out_row, vecs[i].n_cols, 1'b0);
         check($sformatf("vec%0d table_cmds", i), got_q.size(), vecs[i].exp_cmds);
         check($sformatf("vec%0d table_reads", i), rd_q.size(), vecs[i].exp_reads);
      end

      // Hand-checked row: memory word = address, base 0, stride 30, three columns.
      ready_dly = 0; rsp_dly = 0; mem_xor = '0;
      run_row("hand3", 16'd0, 16'd30, 5'd2, 6'd3, 1'b0);
      check("hand3 rd3",  rd_q[3],  16'd30);
      check("hand3 rd8",  rd_q[8],  16'd62);
      check("hand3 cmp0", 128'(got_q[9]),  128'(mk_cmd(0, 1, 3, 0)));
      check("hand3 acc0", 128'(got_q[10]), 128'(mk_cmd(3, 1, 2, 0)));
      check("hand3 sh1",  128'(got_q[11]), 128'(mk_cmd(5, 4, 33, 0)));
      check("hand3 sh2",  128'(got_q[12]), 128'(mk_cmd(5, 5, 63, 0)));
      check("hand3 cmp1", 128'(got_q[13]), 128'(mk_cmd(0, 1, 4, 0)));
      check("hand3 cmp2", 128'(got_q[17]), 128'(mk_cmd(0, 1, 0, 0)));

      // Start pulse and cfg changes while busy are ignored.
      ready_dly = 1; rsp_dly = 1; mem_xor = 32'h0F0F_0000;
      run_row("busy_start", 16'd500, 16'd64, 5'd9, 6'd4, 1'b1);

      // Asynchronous reset in the middle of the column loop.
      ready_dly = 2; rsp_dly = 1; mem_xor = '0;
      clear_obs();
      pulse_start(16'd10, 16'd40, 5'd3, 6'd5);
      cyc = 0;
      while (got_q.size() < 12 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("mid_row reached_col_loop", got_q.size() >= 12, 1'b1);
      #2 reset_n = 1'b0;
      #1 check("mid_row reset_outputs",
               {busy, done, mem_ren, mem_addr, dp_cmd_valid, dp_rsp_ready, dp_function_id, dp_inputs_0, dp_inputs_1},
               '0);
      repeat (3) @(negedge clk);
      check("mid_row no_done", done_cnt, 0);
      reset_n = 1'b1;
      run_row("after_reset", 16'd10, 16'd40, 5'd3, 6'd5, 1'b0);

      // Random rows with random datapath latencies.
      rand_dly = 1'b1;
      for (int i = 0; i < 6; i++) begin
         mem_xor = $urandom;
         run_row($sformatf("rand%0d", i), 16'($urandom), 16'($urandom_range(0, 2000)),
                 5'($urandom_range(0, 27)), 6'($urandom_range(0, 34)), i[0]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_row_sequencer.md
Name: conv_row_sequencer

Overview:
Master-side controller that drives the 3x3x4 MAC convolution datapath over its CFU command/response handshake. For one output row it fetches packed int8x4 input words from a word-addressed input buffer, primes the 9-word window, and loops over output columns issuing compute, accumulate and shift commands. Sits between the layer-level software/controller (start/done) and the datapath; filters are loaded beforehand by software.

Parameters:
- ADDR_W, 16, input-buffer word address width
- COL_W, 5, width of column/row indices (0..27)
- OUT_DIM, 28, max output columns per row

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- cfg_base  in  ADDR_W  word address of window row 0, col 0
- cfg_stride  in  ADDR_W  words per input row
- cfg_out_row  in  COL_W  output row index passed to accumulate
- cfg_n_cols  in  COL_W+1  output columns to produce (0..OUT_DIM)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of row
- mem_ren  out  1  input-buffer read strobe
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  32  read data, valid exactly 1 cycle after mem_ren
- dp_cmd_valid  out  1  command to datapath
- dp_cmd_ready  in  1  datapath accepts
- dp_function_id  out  10  {group[9:3], op[2:0]}
- dp_inputs_0  out  32  payload 0
- dp_inputs_1  out  32  payload 1
- dp_rsp_valid  in  1  datapath response
- dp_rsp_ready  out  1  response accept

Behaviour:
- Reset: state IDLE; busy, done, mem_ren, dp_cmd_valid, dp_rsp_ready = 0; mem_addr, dp_function_id, dp_inputs_0/1 = 0; counters = 0. Reset mid-row aborts immediately; no done.
- start in IDLE latches all cfg_* inputs; later cfg changes are ignored. start while busy is ignored.
- cfg_n_cols == 0: done pulses in the cycle after start, busy never rises, no memory or dp traffic. cfg_n_cols > OUT_DIM is clamped to OUT_DIM.
- Address of window word (r, c) = base + r*stride + c, mod 2^ADDR_W (wrap, no error).
- Each dp transaction: drive dp_cmd_valid with stable payload until dp_cmd_valid & dp_cmd_ready; then drop valid, hold dp_rsp_ready=1 until dp_rsp_valid; next command no earlier than the cycle after the response. Response data is ignored.
- Each fetch: mem_ren one cycle; data captured the following cycle into the payload register.
- States: IDLE -> PRIME (9 fetch+issue pairs, r=0..2 outer, c=0..2 inner, function ids {4,1},{4,2},{4,3} for row 0; {4,4},{4,5},{4,6} row 1; {5,1},{5,2},{5,3} row 2) -> COL loop -> DONE -> IDLE.
- COL loop for output column k (0..n-1):
  - CMP: fetch (0, k+3), issue {0,1} with inputs_0 = that word (computes current window, shifts row 0).
  - ACC: issue {3,1}, inputs_0 = out_row, inputs_1 = k.
  - SH1: fetch (1, k+3), issue {5,4}. SH2: fetch (2, k+3), issue {5,5}.
  - Last column (k = n-1): CMP issues inputs_0 = 0 without a fetch; SH1/SH2 skipped.
- DONE: done=1 for one cycle, busy drops in the same cycle.
- Commands {3,0} and {4,0} (no response from datapath) are never issued.

Optional Feature:
- CONV_SEQ_PERF_EN: adds output perf_cycles (32 bit) counting cycles with busy=1 for the last row, cleared on accepted start, saturating at 2^32-1, held after done. Without it the port and counter are absent.

Decomposition:
- Shared package conv_cfu_pkg: function-id group/op localparams (GRP_COMPUTE=0, GRP_ACC=3, GRP_IN_A=4, GRP_IN_B=5, op codes), state enum, OUT_DIM.
- Sub-module dp_cmd_master: one-shot command/response handshake engine (issue, wait ready, wait response, report idle); the sequencer FSM instantiates one.

Test Plan:
- base=0, stride=30, out_row=2, n_cols=1, dp ready/rsp immediate -> 9 prime cmds, then {0,1} inputs_0=0, {3,1} (2,0); exactly 11 cmds, 9 reads, done once.
- n_cols=3, memory word = address -> prime reads addr 0,1,2,30,31,32,60,61,62; col0 payloads 3,(row,0),33,63; col1 4,34,64; col2 CMP payload 0.
- dp_cmd_ready held low 5 cycles and rsp delayed 3 cycles per command -> payload stable while valid, no command overlaps, same sequence as zero-wait.
- n_cols=0 -> done one cycle after start, zero dp_cmd_valid/mem_ren activity.
- start pulsed again while busy, cfg changed mid-row -> ignored; addresses use latched cfg.
- reset_n asserted mid COL loop -> all outputs 0 asynchronously; after release, new start completes a full correct row.
